// File: rtl/cpu_pkg.sv
// Shared opcode, state and instruction-field definitions for the decode/execute stage.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_LDI = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_JZ  = 4'hC;
  localparam logic [3:0] OP_JC  = 4'hD;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    ST_EXEC  = 2'd0,
    ST_IMM   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Instruction byte layout: op[7:4] rd[3:2] rs[1:0]
  localparam int OP_MSB = 7;
  localparam int OP_LSB = 4;
  localparam int RD_MSB = 3;
  localparam int RD_LSB = 2;
  localparam int RS_MSB = 1;
  localparam int RS_LSB = 0;

endpackage

// File: rtl/de_alu.sv
// Combinational ALU for the single-byte ops 1-9; reports whether flags should update.
module de_alu
  import cpu_pkg::*;
(
  input  logic [3:0] i_op,
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_y,
  output logic       o_c,
  output logic       o_z,
  output logic       o_wr_flags
);

  logic [8:0] w_sum;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};

  always_comb begin
    o_y        = 8'h00;
    o_c        = 1'b0;
    o_wr_flags = 1'b1;
    case (i_op)
      OP_MOV: o_y = i_b;
      OP_ADD: {o_c, o_y} = w_sum;
      OP_SUB: begin
        o_y = i_a - i_b;
        o_c = (i_a < i_b);
      end
      OP_AND: o_y = i_a & i_b;
      OP_OR:  o_y = i_a | i_b;
      OP_XOR: o_y = i_a ^ i_b;
      OP_NOT: o_y = ~i_b;
      OP_SHL: begin
        o_y = {i_b[6:0], 1'b0};
        o_c = i_b[7];
      end
      OP_SHR: begin
        o_y = {1'b0, i_b[7:1]};
        o_c = i_b[0];
      end
      default: o_wr_flags = 1'b0;
    endcase
  end

  assign o_z = (o_y == 8'h00);

endmodule

// File: rtl/decode_execute.sv
// Decode/execute stage: runs the fetched byte stream against a 4x8 register file,
// handles two-byte ops with a small FSM and redirects fetch on taken branches.
module decode_execute
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  // Valid-only stream: a byte is consumed on every rising edge where i_ir_valid
  // is high in EXEC/IMM; there is no ready, fetch never waits on this stage.
  input  logic       i_ir_valid,
  input  logic [7:0] i_ir,
  output logic       o_redirect,
  output logic [7:0] o_redirect_pc,
  output logic       o_out_valid,
  output logic [7:0] o_out_data,
  output logic       o_flag_z,
  output logic       o_flag_c,
  output logic       o_halted,
  output state_t     o_dbg_state
);

  state_t     r_state;
  logic [7:0] r_regs [4];
  logic       r_z;
  logic       r_c;
  logic [3:0] r_op;
  logic [1:0] r_rd;
  logic       r_redirect;
  logic [7:0] r_redirect_pc;
  logic       r_out_valid;
  logic [7:0] r_out_data;
  logic       r_halted;

  logic [3:0] w_op;
  logic [1:0] w_rd;
  logic [1:0] w_rs;
  logic [7:0] w_y;
  logic       w_c;
  logic       w_z;
  logic       w_wr_flags;
  logic       w_taken;

  assign w_op = i_ir[OP_MSB:OP_LSB];
  assign w_rd = i_ir[RD_MSB:RD_LSB];
  assign w_rs = i_ir[RS_MSB:RS_LSB];

  de_alu u_alu (
    .i_op       (w_op),
    .i_a        (r_regs[w_rd]),
    .i_b        (r_regs[w_rs]),
    .o_y        (w_y),
    .o_c        (w_c),
    .o_z        (w_z),
    .o_wr_flags (w_wr_flags)
  );

  // Branch condition uses the flags as they stand in the IMM cycle.
  always_comb begin
    w_taken = 1'b0;
    case (r_op)
      OP_JMP:  w_taken = 1'b1;
      OP_JZ:   w_taken = r_z;
      OP_JC:   w_taken = r_c;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_EXEC;
      for (int i = 0; i < 4; i++) r_regs[i] <= 8'h00;
      r_z           <= 1'b0;
      r_c           <= 1'b0;
      r_op          <= OP_NOP;
      r_rd          <= 2'd0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= RESET_PC;
      r_out_valid   <= 1'b0;
      r_out_data    <= 8'h00;
      r_halted      <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_redirect  <= 1'b0;
      case (r_state)
        ST_EXEC: begin
          if (i_ir_valid) begin
            if (w_wr_flags) begin
              r_regs[w_rd] <= w_y;
              r_z          <= w_z;
              r_c          <= w_c;
            end
            case (w_op)
              OP_LDI, OP_JMP, OP_JZ, OP_JC: begin
                r_op    <= w_op;
                r_rd    <= w_rd;
                r_state <= ST_IMM;
              end
              OP_OUT: begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_regs[w_rs];
              end
              OP_HLT: begin
                r_halted <= 1'b1;
                r_state  <= ST_HALT;
              end
              default: ;
            endcase
          end
        end
        ST_IMM: begin
          if (i_ir_valid) begin
            if (r_op == OP_LDI) begin
              r_regs[r_rd] <= i_ir;
              r_state      <= ST_EXEC;
            end else if (w_taken) begin
              r_redirect_pc <= i_ir;
              r_redirect    <= 1'b1;
              r_state       <= ST_FLUSH;
            end else begin
              r_state <= ST_EXEC;
            end
          end
        end
        // The byte in flight behind a taken branch is dropped here.
        ST_FLUSH: r_state <= ST_EXEC;
        ST_HALT:  r_state <= ST_HALT;
        default:  r_state <= ST_EXEC;
      endcase
    end
  end

  assign o_redirect    = r_redirect;
  assign o_redirect_pc = r_redirect_pc;
  assign o_out_valid   = r_out_valid;
  assign o_out_data    = r_out_data;
  assign o_flag_z      = r_z;
  assign o_flag_c      = r_c;
  assign o_halted      = r_halted;
  assign o_dbg_state   = r_state;

endmodule

// File: doc/decode_execute.md
# decode_execute

Consumes the 8-bit instruction byte stream that the fetch stage presents on `ir` every cycle and executes it against a 4×8 register file with Z/C flags. It is the stage directly downstream of fetch. It handles two-byte instructions (immediate load, branches) with a small state machine. It drives a one-cycle PC redirect back to fetch for taken branches, and squashes the single wrong-path byte already in flight.

## Interface
- `RESET_PC`, default 8'h00: value loaded into `redirect_pc` at reset.
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `ir_valid`  in  1  `ir` holds a byte to consume this cycle; tied high when fed by fetch.
- `ir`  in  8  instruction or operand byte; format `op[7:4] rd[3:2] rs[1:0]`.
- `redirect`  out  1  one-cycle pulse; fetch loads `redirect_pc` into PC on that edge.
- `redirect_pc`  out  8  branch target.
- `out_valid`  out  1  one-cycle pulse when OUT executes.
- `out_data`  out  8  value written by OUT; holds until the next OUT.
- `flag_z`, `flag_c`  out  1 each  current flags.
- `halted`  out  1  high after HLT until reset.

## Operation
- Opcodes:
  - 0 NOP
  - 1 MOV rd←rs
  - 2 ADD rd←rd+rs
  - 3 SUB rd←rd−rs
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 NOT rd←~rs
  - 8 SHL rd←rs<<1
  - 9 SHR rd←rs>>1 (logical)
  - A LDI rd,#imm
  - B JMP #t
  - C JZ #t
  - D JC #t
  - E OUT rs
  - F HLT
- Arithmetic is 8-bit, wrapping.
  - ADD: C = carry-out of the 9-bit sum.
  - SUB: C = borrow (rd<rs).
  - SHL: C = rs[7]. SHR: C = rs[0].
  - Logic ops, MOV and NOT clear C.
- Z = (result==0). Z is updated by ops 1–9 only; LDI, branches and OUT leave both flags unchanged.
- rd==rs is legal; operands are read before the write.
- States: EXEC, IMM, FLUSH, HALT.
  - EXEC, single-byte op: execute, stay in EXEC.
  - EXEC, op A–D: latch op and rd, go to IMM.
  - EXEC, op F: go to HALT.
  - IMM:
    - LDI writes rd←ir, then EXEC.
    - Taken JMP/JZ/JC: register `redirect_pc`←ir and `redirect`←1, then FLUSH.
    - Not-taken branch: consume the byte, return to EXEC.
  - FLUSH: discard `ir` unconditionally and deassert `redirect`, then EXEC.
  - HALT: ignore `ir`; `halted`=1. Leave only via reset.
- `ir_valid`=0 in EXEC or IMM: hold state, no side effects. FLUSH completes regardless of `ir_valid`.
- JZ/JC evaluate the flags as they are at the IMM cycle.

## Timing
- Reset values:
  - registers R0–R3 = 0
  - Z = 0, C = 0
  - state = EXEC
  - `redirect` = 0, `redirect_pc` = RESET_PC
  - `out_valid` = 0, `out_data` = 0
  - `halted` = 0
- Single-byte ops: the register/flag write lands on the same edge that samples `ir`. The result is visible to the next instruction with no hazard.
- OUT: `out_valid`/`out_data` are registered and high the cycle after OUT is sampled.
- Taken branch (edges counted from EXEC sampling the opcode):
  - edge 1: enter IMM
  - edge 2: immediate captured; `redirect` high during the following cycle (FLUSH)
  - edge 3: fetch loads the target and the FLUSH byte is dropped
  - cycle after edge 3: `ir` = mem[target]
  - Branch penalty: exactly one squashed byte.
- Reset asserted in IMM or FLUSH: the pending operation is abandoned and `redirect` drops immediately (async).
- Opcode byte as last memory byte (PC wrap 0xFF→0x00): the immediate is taken from address 0x00; no special case.

## Structure
- Shared package `cpu_pkg`:
  - opcode localparams OP_NOP..OP_HLT
  - state encoding ST_EXEC/ST_IMM/ST_FLUSH/ST_HALT
  - field slice constants for op/rd/rs
- One combinational sub-module, `de_alu`:
  - inputs: op[3:0], a[7:0], b[7:0]
  - outputs: y[7:0], c, z, wr_flags
- Register file, FSM and output registers stay in `decode_execute`.

## Test plan
- Bytes A0 05, A4 03, 21, E0 → one `out_valid` pulse with `out_data`=08; Z=0, C=0.
- LDI R0=00, LDI R1=01, SUB 31, OUT R0 → `out_data`=FF, C=1, Z=0. Then ADD R0+R1 → R0=00, Z=1, C=1.
- After Z=1, bytes C0 40 then junk byte E0 → `redirect`=1 for exactly one cycle with `redirect_pc`=40; the E0 byte produces no `out_valid`.
- JZ with Z=0 (C0 40) → no `redirect`; the next byte executes normally on the following cycle.
- F0 followed by E0, A0 55 → `halted`=1, no register change, no `out_valid`. Reset → `halted`=0 and all registers 0.
- Assert reset in the IMM cycle of A0 → R0 stays 00, state returns to EXEC, the next byte decodes as an opcode.
